// File: rtl/fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Shares the single write port of the FIFO between NREQ producers using a
//   round-robin arbiter. The current owner keeps the port for at most BURST
//   words while others are waiting. A FIFO-full condition stalls the owner
//   without revoking its grant. Write enable and data go straight to the FIFO.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   req_valid    per-requester valid
//   req_data     per-requester data, lane i at [i*WIDTH +: WIDTH]
//   req_ready    per-requester ready (one-hot or zero)
//   fifo_full    FIFO full flag
//   fifo_wr_en   FIFO write strobe
//   fifo_wdata   FIFO write data (owner lane in GRANT, 0 otherwise)
//   grant_valid  a grant is currently held
//   grant_id     current owner (0 when no grant)
//   xfer_count   running count of words written, wraps at 2^16
//------------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [WIDTH-1:0]          fifo_wdata,
    output logic                      grant_valid,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [15:0]               xfer_count
);

    localparam int IDW = $clog2(NREQ);
    localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] last;
    logic [BCW-1:0] burst_cnt;
    logic [15:0]    count_q;

    logic           in_grant;
    logic           owner_valid;
    logic           xfer;
    logic           rel;
    logic [IDW-1:0] base;
    logic [IDW-1:0] pick;
    logic           pick_found;

    assign in_grant    = (state == S_GRANT);
    assign owner_valid = req_valid[owner];
    assign xfer        = in_grant && owner_valid && !fifo_full;

    // A grant ends when the owner goes quiet or has just written its last
    // allowed word of the burst.
    assign rel = in_grant && (!owner_valid || (xfer && (burst_cnt == BURST_LAST)));

    // Round-robin search starting just after the base index. While granted,
    // the base is the owner itself, so the owner is checked last and only
    // re-wins when nobody else is asking. Iterating from the farthest
    // candidate toward the nearest lets the nearest valid one overwrite.
    always_comb begin
        base       = in_grant ? owner : last;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(base) + k) % NREQ]) begin
                pick       = IDW'((int'(base) + k) % NREQ);
                pick_found = 1'b1;
            end
        end
    end

    // Only the owner sees ready, and only while the FIFO can take a word.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = in_grant && !fifo_full && (int'(owner) == i);
        end
    end

    assign fifo_wr_en  = xfer;
    assign fifo_wdata  = in_grant ? req_data[int'(owner)*WIDTH +: WIDTH] : '0;
    assign grant_valid = in_grant;
    assign grant_id    = owner;
    assign xfer_count  = count_q;

    // Grant state machine. On release with another winner the new owner is
    // installed directly in GRANT, so there is no idle cycle between owners.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            last      <= IDW'(NREQ - 1);
            burst_cnt <= '0;
            count_q   <= '0;
        end else begin
            if (xfer) begin
                count_q <= count_q + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state     <= S_GRANT;
                        owner     <= pick;
                        last      <= pick;
                        burst_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (rel) begin
                        if (pick_found) begin
                            owner     <= pick;
                            last      <= pick;
                            burst_cnt <= '0;
                        end else begin
                            state     <= S_IDLE;
                            owner     <= '0;
                            burst_cnt <= '0;
                        end
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
